// File: rtl/game_ctrl.sv
// game_ctrl: top-level play/hit/game-over sequencer.
// Consumes the attackers' game_over flags and the VGA frame position.
// Drives game_stop back to the attackers and shooter, and keeps lives,
// the per-frame survival score and the high score for the HUD.
// Optional feature macro: GAME_CTRL_DEBOUNCE_EN (start button debouncer).
//
// start_btn path: 2-FF synchronizer -> [debouncer] -> registered rising-edge
// detector producing start_p_q, a one-cycle pulse.
// All outputs come straight from flops and change on the edge where the
// state changes.
module game_ctrl #(
  parameter int N_ATTK     = 5,
  parameter int LIVES_INIT = 3,
  parameter int HIT_FRAMES = 60,
  parameter int DEB_CYCLES = 650000
) (
  input  logic              clk_65M,
  input  logic              clear,
  input  logic              start_btn,
  input  logic [16:0]       H_count,
  input  logic [16:0]       V_count,
  input  logic [N_ATTK-1:0] game_over_vec,
  output logic              game_stop,
  output logic              game_on,
  output logic              game_over,
  output logic [3:0]        lives,
  output logic [15:0]       score,
  output logic [15:0]       hi_score
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_PLAY = 2'd1;
  localparam logic [1:0] ST_HIT  = 2'd2;
  localparam logic [1:0] ST_OVER = 2'd3;

  localparam logic [3:0]  LIVES_LOAD = 4'(LIVES_INIT);
  localparam logic [7:0]  HIT_LOAD   = 8'(HIT_FRAMES);
  localparam logic [15:0] SCORE_MAX  = 16'hFFFF;

  logic frame_tick;
  logic hit;
  logic btn_lvl;

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic lvl_prev_q, lvl_prev_d;
  logic start_p_q, start_p_d;

  logic [1:0]  state_q, state_d;
  logic [3:0]  lives_q, lives_d;
  logic [15:0] score_q, score_d;
  logic [15:0] hi_q, hi_d;
  logic [7:0]  hit_cnt_q, hit_cnt_d;
  logic        game_stop_q, game_stop_d;
  logic        game_on_q, game_on_d;
  logic        game_over_q, game_over_d;

  assign frame_tick = (H_count == 17'd0) && (V_count == 17'd0);
  assign hit        = |game_over_vec;

  // Two-stage synchronizer for the asynchronous push-button.
  always_comb begin
    sync1_d = start_btn;
    sync2_d = sync1_q;
  end

  always_ff @(posedge clk_65M) begin
    if (clear) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

`ifdef GAME_CTRL_DEBOUNCE_EN
  localparam logic [19:0] DEB_LAST = 20'(DEB_CYCLES - 1);

  logic [19:0] deb_cnt_q, deb_cnt_d;
  logic        deb_q, deb_d;

  // Debounced level follows the synchronized level only after it has
  // differed for DEB_CYCLES consecutive cycles; any bounce restarts the count.
  always_comb begin
    deb_d     = deb_q;
    deb_cnt_d = 20'd0;
    if (sync2_q != deb_q) begin
      if (deb_cnt_q == DEB_LAST) begin
        deb_d     = sync2_q;
        deb_cnt_d = 20'd0;
      end else begin
        deb_cnt_d = deb_cnt_q + 20'd1;
      end
    end
  end

  always_ff @(posedge clk_65M) begin
    if (clear) begin
      deb_q     <= 1'b0;
      deb_cnt_q <= 20'd0;
    end else begin
      deb_q     <= deb_d;
      deb_cnt_q <= deb_cnt_d;
    end
  end

  assign btn_lvl = deb_q;
`else
  // Without the debouncer DEB_CYCLES has no function; it stays in the
  // parameter list so both builds share one instantiation.
  logic deb_cycles_unused;
  assign deb_cycles_unused = ^32'(DEB_CYCLES);
  assign btn_lvl = sync2_q;
`endif

  // Registered rising-edge detector: start_p_q is high for one cycle.
  always_comb begin
    lvl_prev_d = btn_lvl;
    start_p_d  = btn_lvl & ~lvl_prev_q;
  end

  always_ff @(posedge clk_65M) begin
    if (clear) begin
      lvl_prev_q <= 1'b0;
      start_p_q  <= 1'b0;
    end else begin
      lvl_prev_q <= lvl_prev_d;
      start_p_q  <= start_p_d;
    end
  end

  // Game state machine with lives, score, hit timer and high score.
  always_comb begin
    state_d   = state_q;
    lives_d   = lives_q;
    score_d   = score_q;
    hi_d      = hi_q;
    hit_cnt_d = hit_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (start_p_q) begin
          state_d = ST_PLAY;
          lives_d = LIVES_LOAD;
          score_d = 16'd0;
        end
      end
      ST_PLAY: begin
        // A hit on the same cycle as frame_tick wins; no score that frame.
        if (hit && (lives_q != 4'd0)) begin
          state_d   = ST_HIT;
          lives_d   = lives_q - 4'd1;
          hit_cnt_d = HIT_LOAD;
        end else if (frame_tick && (score_q != SCORE_MAX)) begin
          score_d = score_q + 16'd1;
        end
      end
      ST_HIT: begin
        if (frame_tick) begin
          hit_cnt_d = hit_cnt_q - 8'd1;
          if (hit_cnt_q == 8'd1) begin
            state_d = (lives_q == 4'd0) ? ST_OVER : ST_PLAY;
          end
        end
      end
      ST_OVER: begin
        // Score is frozen in OVER, so this settles on the first OVER cycle.
        if (score_q > hi_q) begin
          hi_d = score_q;
        end
        if (start_p_q) begin
          state_d = ST_PLAY;
          lives_d = LIVES_LOAD;
          score_d = 16'd0;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Flag outputs are decoded from the next state so they move with it.
  always_comb begin
    game_stop_d = (state_d != ST_PLAY);
    game_on_d   = (state_d == ST_PLAY);
    game_over_d = (state_d == ST_OVER);
  end

  // State and output registers; clear works from any state.
  always_ff @(posedge clk_65M) begin
    if (clear) begin
      state_q     <= ST_IDLE;
      lives_q     <= 4'd0;
      score_q     <= 16'd0;
      hi_q        <= 16'd0;
      hit_cnt_q   <= 8'd0;
      game_stop_q <= 1'b1;
      game_on_q   <= 1'b0;
      game_over_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      lives_q     <= lives_d;
      score_q     <= score_d;
      hi_q        <= hi_d;
      hit_cnt_q   <= hit_cnt_d;
      game_stop_q <= game_stop_d;
      game_on_q   <= game_on_d;
      game_over_q <= game_over_d;
    end
  end

  assign game_stop = game_stop_q;
  assign game_on   = game_on_q;
  assign game_over = game_over_q;
  assign lives     = lives_q;
  assign score     = score_q;
  assign hi_score  = hi_q;

endmodule
